clken_gen_mc: RTL and testbench

CLKEN_GEN_MC -- requirements
Module: clken_gen_mc

---
 rtl/clken_pkg.sv | 11 +
 rtl/clken_chan.sv | 47 ++++
 rtl/clken_gen_mc.sv | 40 ++++
 tb/tb_clken_gen_mc.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/clken_pkg.sv
// clken_pkg: divisor presets shared by the clock-enable generator
package clken_pkg;
  localparam int DIV_100HZ   = 499_999;
  localparam int DIV_1KHZ    = 49_999;
  localparam int DIV_10KHZ   = 4_999;
  localparam int DIV_100KHZ  = 499;
  localparam int DIV_1MHZ    = 49;
  localparam int DIV_10MHZ   = 4;
  localparam int DIV_25MHZ   = 1;
  localparam int DIV_DEFAULT = DIV_1KHZ;
endpackage

// File: rtl/clken_chan.sv
// clken_chan: one channel's counter, shadowed divisor and registered enable/square outputs
module clken_chan import clken_pkg::*; #(
  parameter int CW = 24
) (
  input  logic          clk_50M,
  input  logic          rst_n,
  input  logic          wr,
  input  logic [CW-1:0] wdiv,
  input  logic          en,
  input  logic          restart,
  output logic          clken,
  output logic          clk_sq,
  output logic          pend
);
  logic [CW-1:0] cnt, act, shadow, cnt_nx, act_nx;
  logic run, bnd, apply;
  // run delays the first increment by one edge after enable is sampled
  always_comb begin
    bnd    = run && en && cnt == act;
    apply  = pend && (restart || !en || bnd);
    act_nx = apply ? shadow : act;
    cnt_nx = (restart || !en || !run || bnd) ? '0 : cnt + CW'(1);
  end
  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      act    <= CW'(DIV_DEFAULT);
      shadow <= CW'(DIV_DEFAULT);
      pend   <= 1'b0;
      run    <= 1'b0;
      clken  <= 1'b0;
      clk_sq <= 1'b0;
    end else begin
      run    <= en;
      cnt    <= cnt_nx;
      act    <= act_nx;
      clken  <= bnd && !restart;
      clk_sq <= en && cnt_nx < (act_nx >> 1) + CW'(1);
      if (wr) begin
        shadow <= wdiv;
        pend   <= 1'b1;
      end else if (apply) begin
        pend   <= 1'b0;
      end
    end
  end
endmodule

// File: rtl/clken_gen_mc.sv
// clken_gen_mc: multi-channel clock-enable generator with glitch-free divisor updates
module clken_gen_mc import clken_pkg::*; #(
  parameter int NCH = 4,
  parameter int CW  = 24,
  parameter int CHW = 2
) (
  input  logic           clk_50M,
  input  logic           rst_n,
  input  logic           cfg_valid,
  output logic           cfg_ready,
  input  logic [CHW-1:0] cfg_ch,
  input  logic [CW-1:0]  cfg_div,
  input  logic [NCH-1:0] ch_en,
  input  logic           sync_restart,
  output logic [NCH-1:0] clken,
  output logic [NCH-1:0] clk_sq,
  output logic [NCH-1:0] pend
);
  localparam int PW = 2**CHW;
  logic [PW-1:0]  pend_x;
  logic [NCH-1:0] wr;
  // indices beyond NCH read a zero-padded pend and are rejected by the range term
  assign pend_x    = PW'(pend);
  assign cfg_ready = !pend_x[cfg_ch] && (32'(cfg_ch) < NCH);
  genvar i;
  for (i = 0; i < NCH; i++) begin : g_ch
    assign wr[i] = cfg_valid && cfg_ready && cfg_ch == CHW'(i);
    clken_chan #(.CW(CW)) u_ch (
      .clk_50M (clk_50M),
      .rst_n   (rst_n),
      .wr      (wr[i]),
      .wdiv    (cfg_div),
      .en      (ch_en[i]),
      .restart (sync_restart),
      .clken   (clken[i]),
      .clk_sq  (clk_sq[i]),
      .pend    (pend[i])
    );
  end
endmodule

// File: tb/tb_clken_gen_mc.sv
// tb_clken_gen_mc: directed scenarios plus randomized run against a period/phase model
module tb_clken_gen_mc;
  localparam int NCH = 4;
  localparam int CW  = 24;
  localparam int CHW = 2;
  logic           clk_50M = 1'b0;
  logic           rst_n = 1'b0;
  logic           cfg_valid = 1'b0;
  logic           cfg_ready;
  logic [CHW-1:0] cfg_ch = '0;
  logic [CW-1:0]  cfg_div = '0;
  logic [NCH-1:0] ch_en = '0;
  logic           sync_restart = 1'b0;
  logic [NCH-1:0] clken, clk_sq, pend;
  int checks = 0;
  int errors = 0;
  int m_per[NCH], m_sh[NCH], m_pos[NCH];
  bit m_pend[NCH], m_run[NCH], m_clk[NCH], m_sq[NCH];

  clken_gen_mc #(.NCH(NCH), .CW(CW), .CHW(CHW)) dut (
    .clk_50M(clk_50M), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_ch(cfg_ch), .cfg_div(cfg_div), .ch_en(ch_en), .sync_restart(sync_restart),
    .clken(clken), .clk_sq(clk_sq), .pend(pend)
  );

  always #10 clk_50M = ~clk_50M;

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_per[i] = 50_000; m_sh[i] = 50_000; m_pos[i] = 0;
      m_pend[i] = 0; m_run[i] = 0; m_clk[i] = 0; m_sq[i] = 0;
    end
  endtask

  // Each channel is a position within a period of m_per cycles; a period ends when the position wraps.
  task automatic model_update();
    bit wr, done;
    wr = cfg_valid && int'(cfg_ch) < NCH && !m_pend[cfg_ch];
    for (int i = 0; i < NCH; i++) begin
      done = 0;
      if (sync_restart || !ch_en[i] || !m_run[i]) m_pos[i] = 0;
      else begin
        m_pos[i] = (m_pos[i] + 1) % m_per[i];
        done = m_pos[i] == 0;
      end
      m_clk[i] = done && !sync_restart;
      if (m_pend[i] && (sync_restart || !ch_en[i] || done)) begin
        m_per[i] = m_sh[i];
        m_pend[i] = 0;
      end
      m_sq[i] = ch_en[i] && m_pos[i] < (m_per[i] + 1) / 2;
      m_run[i] = ch_en[i];
    end
    if (wr) begin
      m_sh[cfg_ch] = int'(cfg_div) + 1;
      m_pend[cfg_ch] = 1;
    end
  endtask

  task automatic step();
    @(posedge clk_50M);
    if (rst_n) model_update(); else model_reset();
    @(negedge clk_50M);
  endtask

  task automatic wr_cfg(input int ch, input int div);
    cfg_valid = 1'b1; cfg_ch = CHW'(ch); cfg_div = CW'(div);
    step();
    cfg_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; cfg_valid = 1'b0; ch_en = '0; sync_restart = 1'b0; cfg_ch = '0;
    model_reset();
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    step(); step();
    checks++; if (clken !== '0) begin errors++; $display("FAIL reset_clken got %b exp 0000", clken); end
    checks++; if (clk_sq !== '0) begin errors++; $display("FAIL reset_clk_sq got %b exp 0000", clk_sq); end
    checks++; if (pend !== '0) begin errors++; $display("FAIL reset_pend got %b exp 0000", pend); end
    rst_n = 1'b1;
    #1;
    checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", cfg_ready); end
  endtask

  task automatic test_basic();
    do_reset();
    wr_cfg(0, 4);
    step();
    ch_en = 4'b0001;
    for (int k = 0; k <= 15; k++) begin
      step();
      checks++;
      if (clken[0] !== (k > 0 && k % 5 == 0)) begin
        errors++; $display("FAIL basic_clken k=%0d got %b exp %b", k, clken[0], k > 0 && k % 5 == 0);
      end
      checks++;
      if (clk_sq[0] !== (k % 5 < 3)) begin
        errors++; $display("FAIL basic_sq k=%0d got %b exp %b", k, clk_sq[0], k % 5 < 3);
      end
    end
  endtask

  task automatic test_midwrite();
    do_reset();
    wr_cfg(1, 4);
    step();
    ch_en = 4'b0010;
    step(); step(); step();
    wr_cfg(1, 9);
    for (int k = 3; k <= 16; k++) begin
      if (k > 3) step();
      checks++;
      if (pend[1] !== (k < 5)) begin errors++; $display("FAIL mid_pend k=%0d got %b exp %b", k, pend[1], k < 5); end
      checks++;
      if (clken[1] !== (k == 5 || k == 15)) begin
        errors++; $display("FAIL mid_clken k=%0d got %b exp %b", k, clken[1], k == 5 || k == 15);
      end
    end
  endtask

  task automatic test_busy();
    do_reset();
    ch_en = 4'b0100;
    step(); step();
    wr_cfg(2, 2);
    checks++; if (pend[2] !== 1'b1) begin errors++; $display("FAIL busy_pend2 got %b exp 1", pend[2]); end
    cfg_valid = 1'b1; cfg_ch = 2'd2; cfg_div = CW'(6);
    #1;
    checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL busy_ready2 got %b exp 0", cfg_ready); end
    step();
    cfg_ch = 2'd3; cfg_div = CW'(5);
    #1;
    checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL busy_ready3 got %b exp 1", cfg_ready); end
    step();
    cfg_valid = 1'b0;
    checks++; if (pend[3] !== 1'b1) begin errors++; $display("FAIL busy_pend3 got %b exp 1", pend[3]); end
    ch_en = '0;
    step();
    checks++; if (pend !== '0) begin errors++; $display("FAIL busy_apply got %b exp 0000", pend); end
    ch_en = 4'b0100;
    step();
    for (int k = 1; k <= 6; k++) begin
      step();
      checks++;
      if (clken[2] !== (k % 3 == 0)) begin
        errors++; $display("FAIL busy_period k=%0d got %b exp %b", k, clken[2], k % 3 == 0);
      end
    end
  endtask

  task automatic test_div01();
    do_reset();
    wr_cfg(0, 0);
    step();
    ch_en = 4'b0001;
    for (int k = 0; k <= 6; k++) begin
      step();
      checks++;
      if (clken[0] !== (k > 0)) begin errors++; $display("FAIL div0_clken k=%0d got %b exp %b", k, clken[0], k > 0); end
      checks++;
      if (clk_sq[0] !== 1'b1) begin errors++; $display("FAIL div0_sq k=%0d got %b exp 1", k, clk_sq[0]); end
    end
    wr_cfg(0, 1);
    checks++; if (clken[0] !== 1'b1) begin errors++; $display("FAIL div1_accept got %b exp 1", clken[0]); end
    for (int k = 1; k <= 8; k++) begin
      step();
      checks++;
      if (clken[0] !== (k % 2 == 1)) begin
        errors++; $display("FAIL div1_clken k=%0d got %b exp %b", k, clken[0], k % 2 == 1);
      end
      checks++;
      if (clk_sq[0] !== (k % 2 == 1)) begin
        errors++; $display("FAIL div1_sq k=%0d got %b exp %b", k, clk_sq[0], k % 2 == 1);
      end
    end
  endtask

  task automatic test_restart();
    do_reset();
    wr_cfg(0, 3);
    wr_cfg(1, 7);
    step();
    ch_en = 4'b0001;
    step(); step(); step();
    ch_en = 4'b0011;
    step(); step();
    sync_restart = 1'b1;
    step();
    sync_restart = 1'b0;
    checks++; if (clken[1:0] !== 2'b00) begin errors++; $display("FAIL restart_clken got %b exp 00", clken[1:0]); end
    for (int k = 1; k <= 16; k++) begin
      step();
      checks++;
      if (clken[1:0] !== {k % 8 == 0, k % 4 == 0}) begin
        errors++; $display("FAIL restart_align k=%0d got %b exp %b", k, clken[1:0], {k % 8 == 0, k % 4 == 0});
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    ch_en = 4'b0001;
    step(); step(); step();
    wr_cfg(0, 4);
    checks++; if (clk_sq[0] !== 1'b1) begin errors++; $display("FAIL arst_pre_sq got %b exp 1", clk_sq[0]); end
    checks++; if (pend[0] !== 1'b1) begin errors++; $display("FAIL arst_pre_pend got %b exp 1", pend[0]); end
    #5 rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if ({clken, clk_sq, pend} !== '0) begin
      errors++; $display("FAIL arst_outputs got %b/%b/%b exp all 0", clken, clk_sq, pend);
    end
    step();
    rst_n = 1'b1;
    #1;
    checks++; if (pend !== '0) begin errors++; $display("FAIL arst_pend got %b exp 0000", pend); end
    checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL arst_ready got %b exp 1", cfg_ready); end
    for (int k = 0; k <= 25_000; k++) begin
      step();
      if (k == 24_999) begin
        checks++; if (clk_sq[0] !== 1'b1) begin errors++; $display("FAIL arst_div_hi got %b exp 1", clk_sq[0]); end
      end
      if (k == 25_000) begin
        checks++; if (clk_sq[0] !== 1'b0) begin errors++; $display("FAIL arst_div_lo got %b exp 0", clk_sq[0]); end
      end
    end
  endtask

  task automatic test_random();
    logic [NCH-1:0] ec, es, ep;
    bit er;
    do_reset();
    ch_en = 4'b1111;
    for (int n = 0; n < 1500; n++) begin
      for (int i = 0; i < NCH; i++) if ($urandom_range(0, 19) == 0) ch_en[i] = ~ch_en[i];
      cfg_valid = $urandom_range(0, 3) == 0;
      cfg_ch = CHW'($urandom_range(0, NCH - 1));
      cfg_div = CW'($urandom_range(0, 9));
      sync_restart = $urandom_range(0, 29) == 0;
      #1;
      er = !m_pend[cfg_ch];
      checks++;
      if (cfg_ready !== er) begin errors++; $display("FAIL rand_ready n=%0d got %b exp %b", n, cfg_ready, er); end
      step();
      for (int i = 0; i < NCH; i++) begin
        ec[i] = m_clk[i]; es[i] = m_sq[i]; ep[i] = m_pend[i];
      end
      checks++;
      if ({clken, clk_sq, pend} !== {ec, es, ep}) begin
        errors++;
        $display("FAIL rand_out n=%0d got clken=%b sq=%b pend=%b exp clken=%b sq=%b pend=%b", n, clken, clk_sq, pend, ec, es, ep);
      end
    end
    cfg_valid = 1'b0;
    sync_restart = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_midwrite();
    test_busy();
    test_div01();
    test_restart();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
